// File: rtl/grayscale_vga_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : grayscale_vga_transmitter
// Description : Output stage of the edge-detection pipeline. Grayscale pixels
//               arrive over a valid/ready handshake and are buffered in a small
//               FIFO. The module generates VGA raster timing and replays the
//               buffered pixels, replicated to RGB, aligned to the frame start.
//
// Ports       : I_CLK          system clock
//               I_RESET        asynchronous, active-high reset
//               I_PIXEL        grayscale pixel (P_SUBPIXEL_DEPTH bits)
//               I_PIXEL_SOF    first pixel of a frame (column 0, row 0)
//               I_PIXEL_VALID  input pixel valid
//               I_THRESHOLD    binarisation threshold (optional feature only)
//               O_PIXEL_READY  FIFO not full (registered)
//               O_PIXEL_TICK   one-I_CLK strobe per pixel period
//               O_HSYNC        horizontal sync, active-low
//               O_VSYNC        vertical sync, active-low
//               O_DATA_VALID   output lies in the active region
//               O_PIXEL        RGB pixel {g,g,g}
//               O_UNDERFLOW    sticky: FIFO starved or frame misaligned
//
// Options     : GRAYSCALE_VGA_TRANSMITTER_THRESHOLD_EN
//               Adds I_THRESHOLD; active pixels become all-ones when
//               g >= I_THRESHOLD, otherwise black.
//
// Revision    : 1.0 - initial release
// ============================================================================
module grayscale_vga_transmitter #(
    parameter int P_FRAME_COLUMNS  = 640,
    parameter int P_FRAME_ROWS     = 480,
    parameter int P_H_FRONT        = 16,
    parameter int P_H_SYNC         = 96,
    parameter int P_H_BACK         = 48,
    parameter int P_V_FRONT        = 10,
    parameter int P_V_SYNC         = 2,
    parameter int P_V_BACK         = 33,
    parameter int P_PIXEL_DEPTH    = 24,
    parameter int P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
    parameter int P_CLK_DIV        = 2,
    parameter int P_FIFO_DEPTH     = 16
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
    input  logic                        I_PIXEL_SOF,
    input  logic                        I_PIXEL_VALID,
`ifdef GRAYSCALE_VGA_TRANSMITTER_THRESHOLD_EN
    input  logic [P_SUBPIXEL_DEPTH-1:0] I_THRESHOLD,
`endif
    output logic                        O_PIXEL_READY,
    output logic                        O_PIXEL_TICK,
    output logic                        O_HSYNC,
    output logic                        O_VSYNC,
    output logic                        O_DATA_VALID,
    output logic [P_PIXEL_DEPTH-1:0]    O_PIXEL,
    output logic                        O_UNDERFLOW
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = P_FRAME_COLUMNS + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int V_TOTAL = P_FRAME_ROWS + P_V_FRONT + P_V_SYNC + P_V_BACK;
    // +1 so that the exclusive sync end bound always fits in the counter width
    localparam int H_W     = $clog2(H_TOTAL + 1);
    localparam int V_W     = $clog2(V_TOTAL + 1);
    localparam int DIV_W   = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
    localparam int ADDR_W  = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(P_FIFO_DEPTH + 1);
    localparam int ENTRY_W = P_SUBPIXEL_DEPTH + 1;

    localparam logic [H_W-1:0]    C_H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]    C_V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]    C_COLS       = H_W'(P_FRAME_COLUMNS);
    localparam logic [V_W-1:0]    C_ROWS       = V_W'(P_FRAME_ROWS);
    localparam logic [H_W-1:0]    C_HS_START   = H_W'(P_FRAME_COLUMNS + P_H_FRONT);
    localparam logic [H_W-1:0]    C_HS_END     = H_W'(P_FRAME_COLUMNS + P_H_FRONT + P_H_SYNC);
    localparam logic [V_W-1:0]    C_VS_START   = V_W'(P_FRAME_ROWS + P_V_FRONT);
    localparam logic [V_W-1:0]    C_VS_END     = V_W'(P_FRAME_ROWS + P_V_FRONT + P_V_SYNC);
    localparam logic [DIV_W-1:0]  C_DIV_LAST   = DIV_W'(P_CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST  = ADDR_W'(P_FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  C_DEPTH      = CNT_W'(P_FIFO_DEPTH);

    // State encoding
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_FRAME = 2'd1;
    localparam logic [1:0] S_STREAM     = 2'd2;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]         div_q, div_d;
    logic [H_W-1:0]           h_q, h_d;
    logic [V_W-1:0]           v_q, v_d;
    logic                     tick;
    logic                     active;
    logic                     at_origin;
    logic                     in_hsync;
    logic                     in_vsync;

    logic [ENTRY_W-1:0]       mem_q [P_FIFO_DEPTH];
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     ready_q, ready_d;
    logic                     push;
    logic                     pop;
    logic                     empty;
    logic [ENTRY_W-1:0]       head;
    logic                     head_sof;
    logic [P_SUBPIXEL_DEPTH-1:0] head_gray;
    logic [P_PIXEL_DEPTH-1:0] head_rgb;

    logic [1:0]               state_q, state_d;
    logic                     drive_pixel;
    logic                     set_underflow;

    logic                     pixel_tick_q, pixel_tick_d;
    logic                     hsync_q, hsync_d;
    logic                     vsync_q, vsync_d;
    logic                     data_valid_q, data_valid_d;
    logic [P_PIXEL_DEPTH-1:0] pixel_q, pixel_d;
    logic                     underflow_q, underflow_d;

    // ------------------------------------------------------------------
    // Pixel divider and raster counters
    // ------------------------------------------------------------------
    always_comb begin
        tick  = (div_q == C_DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == C_H_LAST) begin
                h_d = '0;
                v_d = (v_q == C_V_LAST) ? '0 : v_q + V_W'(1);
            end else begin
                h_d = h_q + H_W'(1);
            end
        end
    end

    always_comb begin
        active    = (h_q < C_COLS) && (v_q < C_ROWS);
        at_origin = (h_q == '0) && (v_q == '0);
        in_hsync  = (h_q >= C_HS_START) && (h_q < C_HS_END);
        in_vsync  = (v_q >= C_VS_START) && (v_q < C_VS_END);
    end

    // ------------------------------------------------------------------
    // Input FIFO: entries are {sof, gray}
    // ------------------------------------------------------------------
    always_comb begin
        push      = I_PIXEL_VALID && ready_q;
        empty     = (count_q == '0);
        head      = mem_q[rd_ptr_q];
        head_sof  = head[ENTRY_W-1];
        head_gray = head[P_SUBPIXEL_DEPTH-1:0];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == C_ADDR_LAST) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == C_ADDR_LAST) ? '0 : rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Ready reflects the post-update occupancy, so a push can never
        // land on a full FIFO even though ready is registered.
        ready_d = (count_d != C_DEPTH);
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge I_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {I_PIXEL_SOF, I_PIXEL};
        end
    end

    // ------------------------------------------------------------------
    // Pixel colour mapping
    // ------------------------------------------------------------------
`ifdef GRAYSCALE_VGA_TRANSMITTER_THRESHOLD_EN
    always_comb begin
        head_rgb = (head_gray >= I_THRESHOLD) ? {P_PIXEL_DEPTH{1'b1}} : '0;
    end
`else
    always_comb begin
        head_rgb = {3{head_gray}};
    end
`endif

    // ------------------------------------------------------------------
    // Alignment state machine
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty && head_sof) begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (tick && at_origin) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (tick && active) begin
                    if (empty) begin
                        state_d = S_IDLE;
                    end else if (head_sof && !at_origin) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The frame-start tick is itself the first streamed pixel, so the
    // WAIT_FRAME -> STREAM transition also pops and drives the SOF entry.
    always_comb begin
        pop           = 1'b0;
        drive_pixel   = 1'b0;
        set_underflow = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Drop stale pixels until a frame start reaches the head
                pop = !empty && !head_sof;
            end
            S_WAIT_FRAME: begin
                if (tick && at_origin) begin
                    pop         = 1'b1;
                    drive_pixel = 1'b1;
                end
            end
            S_STREAM: begin
                if (tick && active) begin
                    if (empty) begin
                        set_underflow = 1'b1;
                    end else begin
                        pop         = 1'b1;
                        drive_pixel = 1'b1;
                        // An SOF away from the origin means the stream slipped
                        if (head_sof && !at_origin) begin
                            set_underflow = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Video output registers: loaded on tick cycles, held otherwise
    // ------------------------------------------------------------------
    always_comb begin
        pixel_tick_d = tick;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        data_valid_d = data_valid_q;
        pixel_d      = pixel_q;
        underflow_d  = underflow_q | set_underflow;
        if (tick) begin
            hsync_d      = !in_hsync;
            vsync_d      = !in_vsync;
            data_valid_d = active;
            pixel_d      = drive_pixel ? head_rgb : '0;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            div_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            pixel_tick_q <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            data_valid_q <= 1'b0;
            pixel_q      <= '0;
            underflow_q  <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            pixel_tick_q <= pixel_tick_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            data_valid_q <= data_valid_d;
            pixel_q      <= pixel_d;
            underflow_q  <= underflow_d;
        end
    end

    assign O_PIXEL_READY = ready_q;
    assign O_PIXEL_TICK  = pixel_tick_q;
    assign O_HSYNC       = hsync_q;
    assign O_VSYNC       = vsync_q;
    assign O_DATA_VALID  = data_valid_q;
    assign O_PIXEL       = pixel_q;
    assign O_UNDERFLOW   = underflow_q;

endmodule
`default_nettype wire
